// File: rtl/lif_neuron.sv
// rtl/lif_neuron.sv - leaky integrate-and-fire neuron with refractory period and post-spike trace
module lif_neuron #(
    parameter int ACT_W      = 8,
    parameter int POT_W      = 10,
    parameter int THRESHOLD  = 200,
    parameter int LEAK_SHIFT = 3,
    parameter int REFRACT    = 4,
    parameter int TRACE_W    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [ACT_W-1:0]   activation,
    output logic               post_spike,
    output logic [POT_W-1:0]   potential,
    output logic               refractory,
    output logic [TRACE_W-1:0] trace
);

    localparam logic [0:0] INTEG = 1'b0;
    localparam logic [0:0] REFR  = 1'b1;

    localparam logic [POT_W-1:0]   THR       = POT_W'(THRESHOLD);
    localparam logic [3:0]         REFR_LEN  = 4'(REFRACT);
    localparam logic [TRACE_W-1:0] TRACE_MAX = '1;

    logic [0:0]         state;
    logic [3:0]         cnt;
    logic [POT_W-1:0]   leaked;
    logic [POT_W:0]     sum_wide;
    logic [POT_W-1:0]   sum_sat;
    logic               fire;
    logic [TRACE_W-1:0] trace_dec;

    // One spare bit catches overflow so the potential saturates instead of wrapping.
    always_comb begin
        leaked    = potential - (potential >> LEAK_SHIFT);
        sum_wide  = {1'b0, leaked} + {{(POT_W + 1 - ACT_W){1'b0}}, activation};
        sum_sat   = sum_wide[POT_W] ? '1 : sum_wide[POT_W-1:0];
        fire      = (sum_sat >= THR);
        trace_dec = (trace == '0) ? '0 : trace - 1'b1;
    end

    assign refractory = (state == REFR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= INTEG;
            cnt        <= '0;
            potential  <= '0;
            post_spike <= 1'b0;
            trace      <= '0;
        end else if (!enable) begin
            post_spike <= 1'b0;
        end else if (state == INTEG) begin
            if (fire) begin
                post_spike <= 1'b1;
                potential  <= '0;
                trace      <= TRACE_MAX;
                if (REFRACT > 0) begin
                    state <= REFR;
                    cnt   <= REFR_LEN;
                end
            end else begin
                post_spike <= 1'b0;
                potential  <= sum_sat;
                trace      <= trace_dec;
            end
        end else begin
            post_spike <= 1'b0;
            potential  <= '0;
            trace      <= trace_dec;
            cnt        <= cnt - 1'b1;
            if (cnt == 4'd1) begin
                state <= INTEG;
            end
        end
    end

endmodule

// File: tb/tb_lif_neuron.sv
// tb/tb_lif_neuron.sv - table-driven scoreboard bench for lif_neuron
module tb_lif_neuron;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] activation;

    logic       spk_a, refr_a, spk_b, refr_b;
    logic [9:0] pot_a, pot_b;
    logic [3:0] tr_a, tr_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lif_neuron #(.THRESHOLD(200)) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .activation(activation),
        .post_spike(spk_a), .potential(pot_a), .refractory(refr_a), .trace(tr_a)
    );

    lif_neuron #(.THRESHOLD(1023)) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .activation(activation),
        .post_spike(spk_b), .potential(pot_b), .refractory(refr_b), .trace(tr_b)
    );

    typedef struct {
        bit         sel_b;
        bit         rst;
        bit         en;
        logic [7:0] act;
        logic [9:0] pot;
        bit         spk;
        bit         refr;
        logic [3:0] tr;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    function automatic vec_t mk(bit b, bit r, bit e, int a, int p, bit s, bit rf, int t);
        vec_t v;
        v.sel_b = b; v.rst = r; v.en = e; v.act = 8'(a);
        v.pot = 10'(p); v.spk = s; v.refr = rf; v.tr = 4'(t);
        return v;
    endfunction

    task automatic chk(string name, int idx, int act_v, int exp_v);
        checks++;
        if (act_v !== exp_v) begin
            failures++;
            $display("FAIL %s[%0d] actual=%0d required=%0d", name, idx, act_v, exp_v);
        end
    endtask

    task automatic compare(vec_t e, int idx);
        chk("potential",  idx, e.sel_b ? int'(pot_b)  : int'(pot_a),  int'(e.pot));
        chk("post_spike", idx, e.sel_b ? int'(spk_b)  : int'(spk_a),  int'(e.spk));
        chk("refractory", idx, e.sel_b ? int'(refr_b) : int'(refr_a), int'(e.refr));
        chk("trace",      idx, e.sel_b ? int'(tr_b)   : int'(tr_a),   int'(e.tr));
    endtask

    initial begin
        reset = 1'b0; enable = 1'b1; activation = 8'd255;

        // Neuron A (THRESHOLD=200): integrate, fire, refractory, freeze, leak.
        vecs.push_back(mk(0, 1, 1, 100,   0, 0, 0,  0));
        vecs.push_back(mk(0, 0, 1, 100, 100, 0, 0,  0));
        vecs.push_back(mk(0, 0, 1, 100, 188, 0, 0,  0));
        vecs.push_back(mk(0, 0, 1, 100,   0, 1, 1, 15));
        vecs.push_back(mk(0, 0, 0, 100,   0, 0, 1, 15));
        vecs.push_back(mk(0, 0, 1, 100,   0, 0, 1, 14));
        vecs.push_back(mk(0, 0, 1, 100,   0, 0, 1, 13));
        vecs.push_back(mk(0, 0, 1, 100,   0, 0, 1, 12));
        vecs.push_back(mk(0, 0, 1, 100,   0, 0, 0, 11));
        vecs.push_back(mk(0, 0, 1, 100, 100, 0, 0, 10));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 0, 0, 250, 100, 0, 0, 10));
        vecs.push_back(mk(0, 0, 1,   0,  88, 0, 0,  9));
        vecs.push_back(mk(0, 1, 1,  80,   0, 0, 0,  0));
        vecs.push_back(mk(0, 0, 1,  80,  80, 0, 0,  0));
        vecs.push_back(mk(0, 0, 1,   0,  70, 0, 0,  0));
        vecs.push_back(mk(0, 0, 1,   0,  62, 0, 0,  0));
        vecs.push_back(mk(0, 0, 1,   0,  55, 0, 0,  0));
        // Neuron B (THRESHOLD=1023): first edge gives 255, saturates and fires.
        vecs.push_back(mk(1, 1, 1, 255,   0, 0, 0,  0));
        vecs.push_back(mk(1, 0, 1, 255, 255, 0, 0,  0));
        vecs.push_back(mk(1, 0, 1, 255, 479, 0, 0,  0));
        vecs.push_back(mk(1, 0, 1, 255, 675, 0, 0,  0));
        vecs.push_back(mk(1, 0, 1, 255, 846, 0, 0,  0));
        vecs.push_back(mk(1, 0, 1, 255, 996, 0, 0,  0));
        vecs.push_back(mk(1, 0, 1, 255,   0, 1, 1, 15));

        @(negedge clk);
        checks++;
        if (spk_a !== 1'b0 || pot_a !== 10'd0 || refr_a !== 1'b0 || tr_a !== 4'd0) begin
            failures++;
            $display("FAIL reset_hold actual=%0d/%0d/%0d/%0d required=0/0/0/0",
                     spk_a, pot_a, refr_a, tr_a);
        end

        foreach (vecs[i]) begin
            @(negedge clk);
            reset = ~vecs[i].rst; enable = vecs[i].en; activation = vecs[i].act;
            sb.push_back(vecs[i]);
            @(posedge clk);
            #1;
            compare(sb.pop_front(), i);
        end

        // Async reset in the middle of the refractory period.
        @(negedge clk); reset = 1'b0; enable = 1'b1; activation = 8'd100;
        @(negedge clk); reset = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        chk("mid_refr_setup", 0, int'(refr_a), 1);
        @(negedge clk); #2; reset = 1'b0; #1;
        chk("mid_refr_refractory", 0, int'(refr_a), 0);
        chk("mid_refr_trace",      0, int'(tr_a),   0);
        chk("mid_refr_potential",  0, int'(pot_a),  0);
        @(negedge clk); reset = 1'b1; activation = 8'd100;
        @(posedge clk); #1;
        chk("post_reset_potential", 0, int'(pot_a), 100);
        chk("post_reset_refr",      0, int'(refr_a), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
